fht_adc_loader: RTL and testbench
=================================

// Module: fht_adc_loader
// PURPOSE
//  Upstream front end of fht_top. Accepts a stream of signed ADC samples, writes N
//  samples into the four input RAM banks of fht_top in bit-reversed bank order, then
//  pulses start and holds off new samples until the FHT reports ready. Sits between
//  the ADC interface and fht_top (drives iDATA/iADDR_WR/iWE_0..3/iSTART, reads oRDY).
// PARAMETERS
//  D_BIT      16    FHT data width; sample width is D_BIT-1 (no bit expansion)
//  A_BIT      8     bank address width; BANK_SIZE = 2**A_BIT
//  N          1024  frame length, must equal 4*BANK_SIZE (Radix-4)
//  START_GAP  2     idle cycles between last bank write and oSTART (RAM write settle)
// PORTS
//  iCLK       in   1        clock
//  iRESET     in   1        asynchronous reset, active-high
//  iDATA      in   D_BIT-1  signed ADC sample
//  iVALID     in   1        sample valid; ADC cannot stall
//  oREADY     out  1        loader accepts a sample this cycle
//  oDATA      out  D_BIT-1  sample to fht_top iDATA
//  oADDR_WR   out  A_BIT    write address within bank
//  oWE_0..3   out  1 each   bank write enables (one-hot or zero)
//  oSTART     out  1        one-cycle start pulse to fht_top
//  iRDY       in   1        fht_top oRDY (low while transform runs)
//  oBUSY      out  1        high from first accepted sample until iRDY returns high
//  oDROP      out  1        sticky: iVALID seen while oREADY low; cleared by reset only
//  oFRAMES    out  16       count of frames handed to FHT, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 except oREADY=1 on first cycle after reset release; state LOAD,
//   sample counter k=0, gap counter 0. Reset mid-frame discards partial frame; no start.
//  Accept: sample taken when iVALID & oREADY. k in 0..N-1; q = k[A_BIT+1:A_BIT],
//   bank b = {q[0],q[1]}, address = k[A_BIT-1:0].
//  Write latency 1: the cycle after accept, oWE_b=1, oDATA=sample, oADDR_WR=address;
//   all other WE 0. Without accept all WE 0; oDATA/oADDR_WR hold last values.
//  FSM:
//   LOAD : oREADY=1. On accept with k==N-1 -> GAP, k<=0, oREADY drops next cycle.
//   GAP  : oREADY=0; count START_GAP cycles after the final WE cycle -> FIRE.
//   FIRE : oSTART=1 for exactly one cycle; oFRAMES+=1 -> ACK.
//   ACK  : wait iRDY==0 (FHT acknowledged) -> RUN. If iRDY stays 1 for 16 cycles,
//          return to FIRE once (one retry), then RUN regardless.
//   RUN  : wait iRDY==1 -> LOAD; oREADY=1 the following cycle.
//  oBUSY = (k!=0 in LOAD) | state in {GAP,FIRE,ACK,RUN}.
//  iVALID while oREADY=0: sample ignored, oDROP<=1, no WE, k unchanged.
//  iRDY toggling during LOAD/GAP is ignored. No output is combinational from inputs
//   except none: all outputs registered.
//  Width: data passed unmodified (no sign extension; fht_top extends to D_BIT).
// TESTING
//  Ramp 0..1023, iVALID=1 continuous -> sample 0:WE_0 a0; 255:WE_0 a255; 256:WE_2 a0;
//   512:WE_1 a0; 768:WE_3 a0, 1023:WE_3 a255; each exactly one WE per sample.
//  After sample 1023 WE, oSTART high exactly START_GAP+1 cycles later, 1 cycle wide;
//   oFRAMES 0->1.
//  Model iRDY low 3 cycles after oSTART for 500 cycles -> oREADY stays 0, oBUSY 1;
//   oREADY=1 one cycle after iRDY rises; second frame again starts at WE_0 a0.
//  iVALID held high through GAP/RUN -> no WE asserted, oDROP=1 and stays 1.
//  Assert iRESET at sample 300 for 1 cycle -> all WE 0, oSTART never pulses; next
//   accepted sample writes WE_0 a0; oFRAMES=0.
//  iRDY held 1 after oSTART -> second oSTART pulse after 16 cycles, then loader waits
//   in RUN and returns to LOAD immediately (iRDY=1).

Source files
------------

// File: rtl/fht_adc_loader.sv
// ADC front end for fht_top: streams N signed samples into the four FHT input banks
// in bit-reversed bank order, then fires a start pulse and waits for the transform.
module fht_adc_loader #(
  parameter int unsigned D_BIT     = 16,
  parameter int unsigned A_BIT     = 8,
  parameter int unsigned N         = 1024,
  parameter int unsigned START_GAP = 2
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic [D_BIT-2:0]   iDATA,
  input  logic               iVALID,
  output logic               oREADY,
  output logic [D_BIT-2:0]   oDATA,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic               oWE_0,
  output logic               oWE_1,
  output logic               oWE_2,
  output logic               oWE_3,
  output logic               oSTART,
  input  logic               iRDY,
  output logic               oBUSY,
  output logic               oDROP,
  output logic [15:0]        oFRAMES
);

  localparam int unsigned K_W        = A_BIT + 2;
  localparam int unsigned G_W        = $clog2(START_GAP + 2);
  localparam int unsigned ACK_CYCLES = 16;
  localparam int unsigned C_W        = 4;

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_GAP  = 3'd1,
    S_FIRE = 3'd2,
    S_ACK  = 3'd3,
    S_RUN  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [G_W-1:0]     gap_q, gap_d;
  logic [C_W-1:0]     ack_q, ack_d;
  logic               retry_q, retry_d;
  logic [3:0]         we_q, we_d;
  logic [D_BIT-2:0]   data_q, data_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic [15:0]        frames_q, frames_d;
  logic               accept;
  logic [1:0]         bank;

  // Bank index is the bit-reversed quarter of the frame: q = k[A+1:A], bank = {q[0],q[1]}.
  assign accept = iVALID & ready_q;
  assign bank   = {k_q[A_BIT], k_q[A_BIT+1]};

  // Next-state, sample capture and registered-output precompute.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    gap_d    = '0;
    ack_d    = '0;
    retry_d  = retry_q;
    we_d     = '0;
    data_d   = data_q;
    addr_d   = addr_q;
    frames_d = frames_q;
    drop_d   = drop_q | (iVALID & ~ready_q);

    if (accept) begin
      data_d   = iDATA;
      addr_d   = k_q[A_BIT-1:0];
      we_d[bank] = 1'b1;
    end

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (k_q == K_W'(N - 1)) begin
            k_d     = '0;
            state_d = S_GAP;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      S_GAP: begin
        retry_d = 1'b0;
        if (gap_q == G_W'(START_GAP)) state_d = S_FIRE;
        else                          gap_d   = gap_q + G_W'(1);
      end
      S_FIRE: begin
        frames_d = frames_q + 16'd1;
        state_d  = S_ACK;
      end
      S_ACK: begin
        // One re-fire if the FHT never drops its ready; after that, proceed anyway.
        if (!iRDY) begin
          state_d = S_RUN;
        end else if (ack_q == C_W'(ACK_CYCLES - 1)) begin
          if (retry_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FIRE;
            retry_d = 1'b1;
          end
        end else begin
          ack_d = ack_q + C_W'(1);
        end
      end
      S_RUN: begin
        if (iRDY) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    ready_d = (state_d == S_LOAD);
    start_d = (state_d == S_FIRE);
    busy_d  = (state_d == S_LOAD) ? (k_d != '0) : 1'b1;
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q  <= S_LOAD;
      k_q      <= '0;
      gap_q    <= '0;
      ack_q    <= '0;
      retry_q  <= 1'b0;
      we_q     <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b1;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      retry_q  <= retry_d;
      we_q     <= we_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      frames_q <= frames_d;
    end
  end

  assign oREADY   = ready_q;
  assign oDATA    = data_q;
  assign oADDR_WR = addr_q;
  assign oWE_0    = we_q[0];
  assign oWE_1    = we_q[1];
  assign oWE_2    = we_q[2];
  assign oWE_3    = we_q[3];
  assign oSTART   = start_q;
  assign oBUSY    = busy_q;
  assign oDROP    = drop_q;
  assign oFRAMES  = frames_q;

endmodule

// File: tb/tb_fht_adc_loader.sv
// Randomized bench for fht_adc_loader: per-sample bank/address prediction, start timing,
// handshake retry, drop flag and mid-frame reset against a frame-level model.
module tb_fht_adc_loader;

  localparam int D_BIT     = 16;
  localparam int A_BIT     = 8;
  localparam int N         = 1024;
  localparam int START_GAP = 2;
  localparam int DW        = D_BIT - 1;
  localparam int BANK      = 1 << A_BIT;

  logic           iCLK = 1'b0;
  logic           iRESET, iVALID, iRDY;
  logic [DW-1:0]  iDATA;
  logic           oREADY, oWE_0, oWE_1, oWE_2, oWE_3, oSTART, oBUSY, oDROP;
  logic [DW-1:0]  oDATA;
  logic [A_BIT-1:0] oADDR_WR;
  logic [15:0]    oFRAMES;
  logic [3:0]     we_v;

  fht_adc_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .N(N), .START_GAP(START_GAP)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR), .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2),
    .oWE_3(oWE_3), .oSTART(oSTART), .iRDY(iRDY), .oBUSY(oBUSY), .oDROP(oDROP),
    .oFRAMES(oFRAMES)
  );

  assign we_v = {oWE_3, oWE_2, oWE_1, oWE_0};
  always #5 iCLK = ~iCLK;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            k_m;
  int            frames_m;
  logic          drop_m;
  logic [DW-1:0] last_data;
  int            last_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Quarter q of the frame lands in bank {q[0],q[1]}.
  function automatic int exp_bank(input int k);
    int q;
    q = (k / BANK) % 4;
    return (q % 2) * 2 + q / 2;
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check_static(input string tag);
    check_eq({tag, "_frames"}, 32'(oFRAMES), 32'(frames_m));
    check_eq({tag, "_drop"},   32'(oDROP),   32'(drop_m));
  endtask

  task automatic load_frame(input bit ramp, input int nsamp);
    bit            v;
    logic [DW-1:0] d;
    while (k_m < nsamp) begin
      v = ramp ? 1'b1 : ($urandom_range(3) != 0);
      d = ramp ? DW'(k_m) : DW'($urandom);
      iVALID = v;
      iDATA  = d;
      if (!ramp) iRDY = 1'($urandom_range(1));
      tick();
      if (v) begin
        check_eq("we_onehot", 32'(we_v), 32'(1) << exp_bank(k_m));
        check_eq("addr", 32'(oADDR_WR), 32'(k_m % BANK));
        check_eq("data", 32'(oDATA), 32'(d));
        last_data = d;
        last_addr = k_m % BANK;
        k_m++;
      end else begin
        check_eq("we_idle", 32'(we_v), 32'(0));
        check_eq("data_hold", 32'(oDATA), 32'(last_data));
        check_eq("addr_hold", 32'(oADDR_WR), 32'(last_addr));
      end
      check_eq("ready_load", 32'(oREADY), 32'(k_m < N));
      check_eq("busy_load", 32'(oBUSY), 32'(k_m != 0));
      check_eq("start_load", 32'(oSTART), 32'(0));
      check_static("load");
    end
  endtask

  // Cycles 1..4 after the final write: gap, start pulse at START_GAP+1, frame count bump.
  task automatic after_load();
    drop_m = drop_m | iVALID;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == START_GAP + 2) frames_m++;
      check_eq("gap_we", 32'(we_v), 32'(0));
      check_eq("gap_start", 32'(oSTART), 32'(c == START_GAP + 1));
      check_eq("gap_ready", 32'(oREADY), 32'(0));
      check_eq("gap_busy", 32'(oBUSY), 32'(1));
      check_static("gap");
    end
  endtask

  initial begin
    int  c;
    bit  done;
    iRESET = 1'b1; iVALID = 1'b0; iRDY = 1'b1; iDATA = '0;
    k_m = 0; frames_m = 0; drop_m = 1'b0; last_data = '0; last_addr = 0;

    repeat (2) @(posedge iCLK);
    #1;
    check_eq("rst_ready", 32'(oREADY), 32'(1));
    check_eq("rst_we", 32'(we_v), 32'(0));
    check_eq("rst_start", 32'(oSTART), 32'(0));
    check_eq("rst_busy", 32'(oBUSY), 32'(0));
    check_static("rst");
    iRESET = 1'b0;
    tick();
    check_eq("post_rst_ready", 32'(oREADY), 32'(1));
    check_eq("post_rst_data", 32'(oDATA), 32'(0));

    // Frame 1: continuous ramp, iVALID left high through gap/run.
    load_frame(1'b1, N);
    after_load();
    tick(); tick();
    check_eq("ack_start", 32'(oSTART), 32'(0));
    iRDY = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
      check_eq("run_ready", 32'(oREADY), 32'(0));
      check_eq("run_busy", 32'(oBUSY), 32'(1));
      check_eq("run_we", 32'(we_v), 32'(0));
      check_eq("run_start", 32'(oSTART), 32'(0));
      check_static("run");
    end
    iRDY = 1'b1; iVALID = 1'b0;
    tick();
    check_eq("rdy_rise_ready", 32'(oREADY), 32'(1));
    check_eq("rdy_rise_busy", 32'(oBUSY), 32'(0));
    check_static("rdy_rise");
    k_m = 0;

    // Frame 2: random samples and gaps; FHT never acknowledges -> one retry.
    load_frame(1'b0, N);
    iVALID = 1'b0; iRDY = 1'b1;
    after_load();
    c = 4; done = 1'b0;
    while (!done && c < 60) begin
      c++;
      tick();
      if (c == START_GAP + 19) frames_m++;
      check_eq("retry_start", 32'(oSTART), 32'(c == START_GAP + 18));
      check_eq("retry_we", 32'(we_v), 32'(0));
      if (oREADY) done = 1'b1;
    end
    check_eq("retry_ready_cycle", 32'(c), 32'(START_GAP + 36));
    check_eq("retry_busy", 32'(oBUSY), 32'(0));
    check_static("retry");
    k_m = 0;

    // Frame 3: reset after 300 samples discards the frame.
    load_frame(1'b0, 300);
    iVALID = 1'b0;
    iRESET = 1'b1;
    #1;
    k_m = 0; frames_m = 0; drop_m = 1'b0; last_data = '0; last_addr = 0;
    check_eq("mid_rst_we", 32'(we_v), 32'(0));
    check_eq("mid_rst_start", 32'(oSTART), 32'(0));
    check_eq("mid_rst_busy", 32'(oBUSY), 32'(0));
    check_eq("mid_rst_ready", 32'(oREADY), 32'(1));
    check_static("mid_rst");
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    iRDY = 1'b1;
    load_frame(1'b0, N);
    iVALID = 1'b0; iRDY = 1'b1;
    after_load();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
